// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst write arbiter for the shared push port of a single FIFO.
// Grants one of NREQ producers for up to BURST_LEN words, stalling everyone while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 4,
    parameter int unsigned BURST_LEN = 4,
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned CW = $clog2(BURST_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               fifo_full,
    output logic [NREQ-1:0]    gnt,
    output logic               fifo_push,
    output logic [DW-1:0]      fifo_data,
    output logic [IW-1:0]      owner,
    output logic               busy
);

    typedef enum logic {StIdle, StBurst} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          arb;
    logic          found;
    logic [IW-1:0] winner;
    logic [IW-1:0] sel;
    logic          sel_valid;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (32'(i) == NREQ - 1) ? '0 : i + IW'(1);
    endfunction

    // ptr is always one past the last arbitration winner, so it doubles as the
    // search start when the current owner drops its request mid-burst.
    always_comb begin : p_search
        int unsigned idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_comb begin
        arb       = (state_q == StIdle) || !req[owner_q];
        sel       = arb ? winner : owner_q;
        sel_valid = arb ? found : 1'b1;

        gnt = '0;
        if (!reset && sel_valid && !fifo_full) gnt[sel] = 1'b1;

        fifo_push = |(req & gnt);
        fifo_data = fifo_push ? req_data[32'(sel)*DW +: DW] : '0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;

        if (fifo_push) begin
            if (arb) begin
                owner_d = sel;
                ptr_d   = next_idx(sel);
                if (BURST_LEN == 1) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    state_d = StBurst;
                    cnt_d   = CW'(1);
                end
            end else if (cnt_q == CW'(BURST_LEN - 1)) begin
                state_d = StIdle;
                cnt_d   = '0;
                ptr_d   = next_idx(owner_q);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (state_q == StBurst && req == '0) begin
            // Owner let go and nobody else wants the port: end the burst.
            state_d = StIdle;
            cnt_d   = '0;
            ptr_d   = next_idx(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == StBurst);

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares the single push port of the team's `fifo` block among NREQ producers.
- Each requester presents a word and a request.
- The arbiter grants one requester at a time, for a burst of up to BURST_LEN words.
- It drives `push` and `data_in` of the FIFO directly and stalls all producers while `fifo_full` is high.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 4, data word width; must match the FIFO `data_in` width.
- BURST_LEN, 4, maximum consecutive words granted to one owner before rotation (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request; requester i holds req[i] high while req_data slice i is valid.
- req_data  input  NREQ*DW  packed words; requester i uses bits [i*DW +: DW].
- fifo_full  input  1  FIFO full flag.
- gnt  output  NREQ  one-hot combinational grant; a word transfers at a rising edge where req[i]&gnt[i]=1.
- fifo_push  output  1  to FIFO `push`; equals |(req&gnt).
- fifo_data  output  DW  to FIFO `data_in`; req_data slice of the granted requester, 0 when no grant.
- owner  output  $clog2(NREQ)  current burst owner index, registered.
- busy  output  1  high while state is BURST, registered.

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high on `reset`.
- Registered state:
  - FSM {IDLE, BURST}.
  - Round-robin pointer `ptr`.
  - `owner`.
  - Burst counter `cnt`, width $clog2(BURST_LEN+1).
- Reset values:
  - state=IDLE, ptr=0, owner=0, cnt=0, busy=0.
  - While reset=1: gnt=0, fifo_push=0, fifo_data=0, regardless of req.
- Zero latency: gnt, fifo_push and fifo_data are combinational from req, fifo_full and the registered state. A word is accepted in the same cycle it is granted.
- Arbitration ("ARB") is active when state=IDLE, or state=BURST with req[owner]=0.
  - Winner: first i with req[i]=1, searching ptr, ptr+1, ... mod NREQ.
  - gnt[winner]=1 only if fifo_full=0.
  - On the transfer edge: owner<=winner, cnt<=1.
    - If BURST_LEN=1 or req drops: state<=IDLE, ptr<=winner+1 mod NREQ.
    - Else: state<=BURST.
- BURST with req[owner]=1:
  - gnt[owner]=!fifo_full. All other gnt bits are 0.
  - Each transfer increments cnt.
  - On the transfer making cnt==BURST_LEN: state<=IDLE, ptr<=owner+1 mod NREQ, cnt<=0.
- Owner drops req mid-burst:
  - The same cycle falls back to ARB, with the search starting at owner+1. The old owner loses its turn.
  - If a new winner transfers, it starts a fresh burst. If nobody requests, state<=IDLE, ptr<=owner+1.
- fifo_full=1:
  - gnt=0 and no transfer.
  - state, owner, cnt and ptr are held. The burst resumes with the same owner when full deasserts.
- No requests in IDLE: all registers hold and outputs are 0.
- Wrap-around: ptr and the winner search wrap modulo NREQ. A requester at index NREQ-1 is followed by index 0.
- Reset mid-burst: the next cycle is IDLE with ptr=0. The partially transferred burst is abandoned and no words are replayed.
- gnt is always one-hot or zero. fifo_push=1 implies exactly one gnt bit is set and fifo_full=0.
- Starvation bound: a continuously requesting requester is granted within (NREQ-1)*BURST_LEN transfers.

Test Plan:
- Reset, then a single requester: req=4'b0001, slice0=4'b0010 for 6 cycles, BURST_LEN=4.
  - gnt=0001 and fifo_push=1 on cycles 1-4, fifo_data=2.
  - Cycle 5 is ARB with only req0 set, so req0 wins again with ptr=1.
  - Check owner=0 and busy toggles as specified.
- All four requesting: req=4'b1111, slices 2, A, E, 6, BURST_LEN=1.
  - Grant order is 0,1,2,3,0 over 5 cycles.
  - fifo_data sequence is 2, A, E, 6, 2.
- fifo_full raised mid-burst: owner=1 after 2 words, fifo_full=1 for 3 cycles.
  - gnt=0 and fifo_push=0 for those cycles, cnt stays 2.
  - After release, 2 more words go from requester 1, then rotation to 2.
- Owner drop: owner=2 in BURST, req[2] falls while req[0]=1.
  - The same cycle grants 0 and fifo_data = slice0 (e.g. 4'b0011).
  - ptr is then 1.
- Wrap: ptr=3, req=4'b1001.
  - Requester 3 is granted first, then requester 0.
- Reset asserted during a burst with req=1111.
  - Next cycle: gnt=0, busy=0, owner=0.
  - The first cycle after reset deasserts grants requester 0.
